// File: rtl/round_banner_ctrl.sv
// Round-number banner overlay: latches a round, waits for a frame boundary, then
// addresses the sprite ROM for a solid phase followed by a blinking phase.
module round_banner_ctrl #(
    parameter int SPR_W        = 64,
    parameter int SPR_H        = 32,
    parameter int POS_X        = 288,
    parameter int POS_Y        = 224,
    parameter int NUM_ROUNDS   = 9,
    parameter int ADDR_W       = 15,
    parameter int SHOW_FRAMES  = 90,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_PERIOD = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              show_req,
    input  logic [3:0]        round_num,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_index,
    output logic [3:0]        palette_index,
    output logic              pixel_on,
    output logic              banner_active,
    output logic              done
);

    localparam int CNT_MAX = (SHOW_FRAMES > BLINK_FRAMES) ? SHOW_FRAMES : BLINK_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [10:0]       X_LO     = 11'(POS_X);
    localparam logic [10:0]       X_HI     = 11'(POS_X + SPR_W);
    localparam logic [10:0]       Y_LO     = 11'(POS_Y);
    localparam logic [10:0]       Y_HI     = 11'(POS_Y + SPR_H);
    localparam logic [ADDR_W-1:0] SPR_SIZE = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(SPR_W);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        SHOW       = 2'd2,
        BLINK      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       round_sel_q, round_sel_d;
    logic             done_q, done_d;
    logic             in_box_q, visible_q, active_q;
    logic [3:0]       palette_index_q, palette_index_d;
    logic             pixel_on_q, pixel_on_d;

    logic             in_box;
    logic             visible;
    logic             active;
    logic             req_legal;
    logic [CNT_W-1:0] blink_phase;
    logic [9:0]       dx, dy;

    assign in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                    ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    assign dx     = DrawX - 10'(POS_X);
    assign dy     = DrawY - 10'(POS_Y);

    // Address is forced to 0 outside the box and while reset is held.
    assign rom_addr = (in_box && !Reset)
                    ? ADDR_W'(round_sel_q) * SPR_SIZE + ADDR_W'(dy) * ROW_LEN + ADDR_W'(dx)
                    : '0;

    assign blink_phase = frame_cnt_q / CNT_W'(BLINK_PERIOD);
    assign active      = (state_q == SHOW) || (state_q == BLINK);
    assign visible     = (state_q == SHOW) || ((state_q == BLINK) && !blink_phase[0]);
    assign req_legal   = show_req && (round_num != 4'd0) && (round_num <= 4'(NUM_ROUNDS));

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        round_sel_d = round_sel_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_legal) begin
                    round_sel_d = round_num - 4'd1;
                    state_d     = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d     = SHOW;
                    frame_cnt_d = '0;
                end
            end
            SHOW: begin
                if (frame_start) begin
                    if (frame_cnt_q == CNT_W'(SHOW_FRAMES - 1)) begin
                        state_d     = BLINK;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            BLINK: begin
                if (frame_start) begin
                    if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                        state_d     = IDLE;
                        frame_cnt_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Second pipeline stage: qualifiers delayed one cycle meet the ROM data here.
    always_comb begin
        pixel_on_d      = in_box_q && visible_q && active_q && (rom_index != 4'd0);
        palette_index_d = pixel_on_d ? rom_index : 4'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= IDLE;
            frame_cnt_q     <= '0;
            round_sel_q     <= 4'd0;
            done_q          <= 1'b0;
            in_box_q        <= 1'b0;
            visible_q       <= 1'b0;
            active_q        <= 1'b0;
            pixel_on_q      <= 1'b0;
            palette_index_q <= 4'd0;
        end else begin
            state_q         <= state_d;
            frame_cnt_q     <= frame_cnt_d;
            round_sel_q     <= round_sel_d;
            done_q          <= done_d;
            in_box_q        <= in_box;
            visible_q       <= visible;
            active_q        <= active;
            pixel_on_q      <= pixel_on_d;
            palette_index_q <= palette_index_d;
        end
    end

    assign banner_active = active;
    assign done          = done_q;
    assign pixel_on      = pixel_on_q;
    assign palette_index = palette_index_q;

endmodule

// File: tb/tb_round_banner_ctrl.sv
// Directed bench for round_banner_ctrl: pixel vector table plus lifecycle,
// illegal-request and reset-abort sequences against a behavioural sync ROM.
module tb_round_banner_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        show_req = 1'b0;
    logic [3:0]  round_num = 4'd0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [14:0] rom_addr;
    logic [3:0]  rom_index = 4'd0;
    logic [3:0]  palette_index;
    logic        pixel_on;
    logic        banner_active;
    logic        done;

    int n_cmp = 0;
    int n_fail = 0;
    int done_total = 0;

    round_banner_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .show_req     (show_req),
        .round_num    (round_num),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .rom_addr     (rom_addr),
        .rom_index    (rom_index),
        .palette_index(palette_index),
        .pixel_on     (pixel_on),
        .banner_active(banner_active),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    // ROM contents: low nibble xor 3, except nibble C is the transparent key.
    function automatic logic [3:0] rom_fn(input logic [14:0] a);
        if (a[3:0] == 4'hC) return 4'h0;
        if (a[3:0] == 4'h3) return 4'hF;
        return a[3:0] ^ 4'h3;
    endfunction

    always @(posedge Clk) rom_index <= rom_fn(rom_addr);

    always @(negedge Clk) if (done) done_total++;

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [14:0] addr;
        logic        on;
        logic [3:0]  idx;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic request(input logic [3:0] r);
        show_req  = 1'b1;
        round_num = r;
        step();
        show_req  = 1'b0;
        round_num = 4'd0;
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y,
                         output logic on, output logic [3:0] idx);
        DrawX = x;
        DrawY = y;
        step();
        step();
        on  = pixel_on;
        idx = palette_index;
        DrawX = 10'd0;
        DrawY = 10'd0;
    endtask

    initial begin
        logic       on;
        logic [3:0] idx;
        int         ended;
        logic       done_at;
        int         done_before;

        // Round 6 base = 5*2048 = 10240
        vecs[0] = '{10'd288, 10'd224, 15'd10240, 1'b1, 4'd3};
        vecs[1] = '{10'd352, 10'd224, 15'd0,     1'b0, 4'd0};
        vecs[2] = '{10'd300, 10'd224, 15'd10252, 1'b0, 4'd0};
        vecs[3] = '{10'd351, 10'd255, 15'd12287, 1'b1, 4'd12};
        vecs[4] = '{10'd287, 10'd224, 15'd0,     1'b0, 4'd0};
        vecs[5] = '{10'd288, 10'd256, 15'd0,     1'b0, 4'd0};
        vecs[6] = '{10'd289, 10'd225, 15'd10305, 1'b1, 4'd2};
        vecs[7] = '{10'd320, 10'd240, 15'd11296, 1'b1, 4'd3};
        vecs[8] = '{10'd288, 10'd223, 15'd0,     1'b0, 4'd0};
        vecs[9] = '{10'd295, 10'd224, 15'd10247, 1'b1, 4'd4};

        // Reset held with coordinates sweeping the box
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DrawX = 10'(288 + 30 * i);
            DrawY = 10'(224 + 15 * i);
            step();
            check("rst_pixel_on", int'(pixel_on), 0);
            check("rst_palette", int'(palette_index), 0);
            check("rst_active", int'(banner_active), 0);
            check("rst_done", int'(done), 0);
            check("rst_rom_addr", int'(rom_addr), 0);
        end
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            probe(10'(288 + 20 * i), 10'(224 + 10 * i), on, idx);
            check("idle_pixel_on", int'(on), 0);
            check("idle_palette", int'(idx), 0);
            check("idle_active", int'(banner_active), 0);
        end

        // Request round 6; waiting for frame draws nothing
        request(4'd6);
        check("wait_active", int'(banner_active), 0);
        probe(10'd288, 10'd224, on, idx);
        check("wait_pixel_on", int'(on), 0);
        frame_pulse();
        check("show_active", int'(banner_active), 1);

        foreach (vecs[i]) begin
            DrawX = vecs[i].dx;
            DrawY = vecs[i].dy;
            #1;
            check($sformatf("vec%0d_rom_addr", i), int'(rom_addr), int'(vecs[i].addr));
            step();
            step();
            check($sformatf("vec%0d_pixel_on", i), int'(pixel_on), int'(vecs[i].on));
            check($sformatf("vec%0d_palette", i), int'(palette_index), int'(vecs[i].idx));
        end

        // Busy request must not change the latched round
        request(4'd2);
        DrawX = 10'd288;
        DrawY = 10'd224;
        #1;
        check("busy_rom_addr", int'(rom_addr), 10240);
        DrawX = 10'd0;
        DrawY = 10'd0;

        // Lifecycle: 90 solid + 32 blink frames, then a single done pulse
        ended   = 0;
        done_at = 1'b0;
        for (int p = 1; p <= 200; p++) begin
            frame_pulse();
            if (!banner_active) begin
                ended   = p;
                done_at = done;
                break;
            end
            probe(10'd288, 10'd224, on, idx);
            if (p < 90) check($sformatf("solid_vis_f%0d", p), int'(on), 1);
            else check($sformatf("blink_vis_f%0d", p - 90), int'(on),
                       (((p - 90) / 8) % 2 == 0) ? 1 : 0);
        end
        check("life_frames", ended, 122);
        check("done_pulse", int'(done_at), 1);
        step();
        check("done_width", int'(done), 0);
        check("done_total", done_total, 1);

        // Illegal rounds are ignored in IDLE
        request(4'd0);
        frame_pulse();
        check("illegal0_active", int'(banner_active), 0);
        request(4'd10);
        frame_pulse();
        check("illegal10_active", int'(banner_active), 0);

        // Request coinciding with frame_start: next frame_start enters SHOW
        show_req    = 1'b1;
        round_num   = 4'd3;
        frame_start = 1'b1;
        step();
        show_req    = 1'b0;
        round_num   = 4'd0;
        frame_start = 1'b0;
        check("coinc_active", int'(banner_active), 0);
        frame_pulse();
        check("coinc_show", int'(banner_active), 1);
        DrawX = 10'd288;
        DrawY = 10'd224;
        #1;
        check("r3_rom_addr", int'(rom_addr), 4096);
        probe(10'd288, 10'd224, on, idx);
        check("r3_pixel_on", int'(on), 1);

        // Advance to blink frame 12, then reset
        for (int p = 0; p < 102; p++) frame_pulse();
        check("blink12_active", int'(banner_active), 1);
        probe(10'd288, 10'd224, on, idx);
        check("blink12_hidden", int'(on), 0);
        done_before = done_total;
        DrawX = 10'd288;
        DrawY = 10'd224;
        Reset = 1'b1;
        step();
        check("abort_active", int'(banner_active), 0);
        check("abort_pixel_on", int'(pixel_on), 0);
        check("abort_done", int'(done), 0);
        Reset = 1'b0;
        for (int p = 0; p < 40; p++) frame_pulse();
        check("abort_no_done", done_total, done_before);
        check("abort_idle", int'(banner_active), 0);

        // New request after abort runs normally
        request(4'd1);
        frame_pulse();
        check("rerun_active", int'(banner_active), 1);
        DrawX = 10'd289;
        DrawY = 10'd224;
        #1;
        check("rerun_rom_addr", int'(rom_addr), 1);
        probe(10'd289, 10'd224, on, idx);
        check("rerun_pixel_on", int'(on), 1);
        check("rerun_palette", int'(idx), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
